// File: rtl/widget_motion_scheduler.sv
// Bounces NUM_WIDGETS sprites once per frame; one widget per cycle through one shared step unit.
// Latency: trigger cycle k -> widget i written at end of k+1+i, update_done in k+1+NUM_WIDGETS.
// Backpressure: none; VBlank edges outside IDLE are dropped. Optional WIDGET_PAUSE_EN adds a pause input.
module widget_motion_scheduler #(
  parameter int NUM_WIDGETS = 4,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480
) (
  input  logic                     CLK_100MHz,
  input  logic                     Reset,
  input  logic                     VBlank,
`ifdef WIDGET_PAUSE_EN
  input  logic                     pause,
`endif
  input  logic [8:0]               xSize,
  input  logic [8:0]               ySize,
  input  logic [5*NUM_WIDGETS-1:0]  delX,
  input  logic [5*NUM_WIDGETS-1:0]  delY,
  input  logic [11*NUM_WIDGETS-1:0] firstX,
  input  logic [11*NUM_WIDGETS-1:0] firstY,
  output logic [11*NUM_WIDGETS-1:0] posX,
  output logic [11*NUM_WIDGETS-1:0] posY,
  output logic                     busy,
  output logic                     update_done
);

  localparam int IW = (NUM_WIDGETS > 1) ? $clog2(NUM_WIDGETS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WIDGETS - 1);
  localparam logic [11:0]   H_LIM    = 12'(H_ACTIVE);
  localparam logic [11:0]   V_LIM    = 12'(V_ACTIVE);

  typedef enum logic [1:0] {INIT, IDLE, UPDATE, DONE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [IW-1:0]          idx;
  logic                   vblank_q;
  logic [10:0]            pos_x [NUM_WIDGETS];
  logic [10:0]            pos_y [NUM_WIDGETS];
  logic [NUM_WIDGETS-1:0] dir_x;
  logic [NUM_WIDGETS-1:0] dir_y;

  logic        trigger;
  logic [10:0] cur_x;
  logic [10:0] cur_y;
  logic [4:0]  del_x;
  logic [4:0]  del_y;
  logic        cur_dx;
  logic        cur_dy;
  logic [11:0] res_x;
  logic [11:0] res_y;

  // Returns {dir, pos}; a zero step is a strict hold, even when sitting past the far edge.
  function automatic logic [11:0] step(input logic [10:0] cur, input logic [4:0] del,
                                       input logic [8:0] size, input logic dir,
                                       input logic [11:0] lim);
    logic [11:0] nx;
    logic [11:0] far;
    logic [11:0] r;
    nx  = {1'b0, cur} + {7'd0, del};
    far = nx + {3'd0, size};
    r   = {dir, cur};
    if (del == 5'd0) begin
      r = {dir, cur};
    end else if (dir) begin
      if (far > lim) r = {1'b0, lim[10:0] - {2'b00, size}};
      else           r = {1'b1, nx[10:0]};
    end else begin
      if (cur < {6'd0, del}) r = {1'b1, 11'd0};
      else                   r = {1'b0, cur - {6'd0, del}};
    end
    return r;
  endfunction

  always_comb begin
    cur_x  = '0;
    cur_y  = '0;
    del_x  = '0;
    del_y  = '0;
    cur_dx = 1'b1;
    cur_dy = 1'b1;
    for (int i = 0; i < NUM_WIDGETS; i++) begin
      if (idx == IW'(i)) begin
        cur_x  = pos_x[i];
        cur_y  = pos_y[i];
        del_x  = delX[5*i +: 5];
        del_y  = delY[5*i +: 5];
        cur_dx = dir_x[i];
        cur_dy = dir_y[i];
      end
    end
    res_x = step(cur_x, del_x, xSize, cur_dx, H_LIM);
    res_y = step(cur_y, del_y, ySize, cur_dy, V_LIM);
  end

`ifdef WIDGET_PAUSE_EN
  assign trigger = VBlank && !vblank_q && !pause;
`else
  assign trigger = VBlank && !vblank_q;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    state_nxt = IDLE;
      IDLE:    if (trigger) state_nxt = UPDATE;
      UPDATE:  if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      state    <= INIT;
      idx      <= '0;
      vblank_q <= 1'b1;
      dir_x    <= '1;
      dir_y    <= '1;
      for (int i = 0; i < NUM_WIDGETS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
      end
    end else begin
      state    <= state_nxt;
      vblank_q <= VBlank;
      case (state)
        INIT: begin
          idx   <= '0;
          dir_x <= '1;
          dir_y <= '1;
          for (int i = 0; i < NUM_WIDGETS; i++) begin
            pos_x[i] <= firstX[11*i +: 11];
            pos_y[i] <= firstY[11*i +: 11];
          end
        end
        UPDATE: begin
          pos_x[idx] <= res_x[10:0];
          dir_x[idx] <= res_x[11];
          pos_y[idx] <= res_y[10:0];
          dir_y[idx] <= res_y[11];
          idx        <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
        end
        default: idx <= '0;
      endcase
    end
  end

  always_comb begin
    posX = '0;
    posY = '0;
    for (int i = 0; i < NUM_WIDGETS; i++) begin
      posX[11*i +: 11] = pos_x[i];
      posY[11*i +: 11] = pos_y[i];
    end
  end

  // Gated by Reset so busy drops the instant reset asserts, though the state register sits in INIT.
  assign busy        = Reset && ((state == INIT) || (state == UPDATE));
  assign update_done = (state == DONE);

endmodule

// File: tb/tb_widget_motion_scheduler.sv
// Directed bench for widget_motion_scheduler (NUM_WIDGETS=4, 640x480).
// Pause scenario is compiled in only when WIDGET_PAUSE_EN is defined.
module tb_widget_motion_scheduler;

  logic        clk = 1'b0;
  logic        Reset;
  logic        VBlank;
  logic [8:0]  xSize;
  logic [8:0]  ySize;
  logic [19:0] delX;
  logic [19:0] delY;
  logic [43:0] firstX;
  logic [43:0] firstY;
  logic [43:0] posX;
  logic [43:0] posY;
  logic        busy;
  logic        update_done;
`ifdef WIDGET_PAUSE_EN
  logic        pause;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  widget_motion_scheduler dut (
    .CLK_100MHz (clk),
    .Reset      (Reset),
    .VBlank     (VBlank),
`ifdef WIDGET_PAUSE_EN
    .pause      (pause),
`endif
    .xSize      (xSize),
    .ySize      (ySize),
    .delX       (delX),
    .delY       (delY),
    .firstX     (firstX),
    .firstY     (firstY),
    .posX       (posX),
    .posY       (posY),
    .busy       (busy),
    .update_done(update_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [10:0] gx(input int i);
    return posX[11*i +: 11];
  endfunction

  function automatic logic [10:0] gy(input int i);
    return posY[11*i +: 11];
  endfunction

  task automatic run_frame(output int lat, output logic b1, output logic [10:0] x0,
                           output logic [10:0] y0);
    tick();
    VBlank = 1'b1;
    lat = -1;
    b1  = 1'b0;
    x0  = '0;
    y0  = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) b1 = busy;
      if (c == 2) begin
        x0 = gx(0);
        y0 = gy(0);
      end
      if (update_done) begin
        lat = c;
        break;
      end
    end
    VBlank = 1'b0;
  endtask

  initial begin
    int          lat;
    logic        b1;
    logic [10:0] x0;
    logic [10:0] y0;
    logic        seen;

    Reset  = 1'b0;
    VBlank = 1'b0;
    xSize  = 9'd4;
    ySize  = 9'd4;
    delX   = {5'd0, 5'd6, 5'd0, 5'd6};
    delY   = {5'd0, 5'd0, 5'd0, 5'd4};
    firstX = {11'd10, 11'd632, 11'd200, 11'd100};
    firstY = {11'd10, 11'd100, 11'd3, 11'd50};
`ifdef WIDGET_PAUSE_EN
    pause  = 1'b0;
`endif

    // Reset state
    tick();
    chk("rst_posX", posX, 64'd0);
    chk("rst_posY", posY, 64'd0);
    chk("rst_busy", busy, 0);
    chk("rst_done", update_done, 0);
    Reset = 1'b1;
    #1;
    chk("init_busy", busy, 1);
    tick();
    chk("load_x0", gx(0), 100);
    chk("load_y0", gy(0), 50);
    chk("idle_busy", busy, 0);

    // Frame 1: w0 steps, w2 hits the right edge, w1/w3 zero steps hold
    run_frame(lat, b1, x0, y0);
    chk("f1_lat", lat, 5);
    chk("f1_busy", b1, 1);
    chk("f1_x0_c2", x0, 106);
    chk("f1_y0_c2", y0, 54);
    chk("f1_done_busy", busy, 0);
    chk("f1_x2_clamp", gx(2), 636);
    chk("f1_y1_hold", gy(1), 3);
    chk("f1_x3_hold", gx(3), 10);
    chk("f1_y3_hold", gy(3), 10);

    // Frame 2: tall widget forces w1 to bounce off the bottom at y=3
    ySize = 9'd477;
    delY  = {5'd0, 5'd0, 5'd4, 5'd0};
    run_frame(lat, b1, x0, y0);
    chk("f2_lat", lat, 5);
    chk("f2_x2_back", gx(2), 630);
    chk("f2_y1_bounce", gy(1), 3);
    chk("f2_x0", gx(0), 112);
    chk("f2_y0_hold", gy(0), 54);

    // Frame 3: w1 moving up with y=3 < 4 clamps to 0
    ySize = 9'd4;
    run_frame(lat, b1, x0, y0);
    chk("f3_y1_top", gy(1), 0);
    chk("f3_x0", gx(0), 118);

    // Frame 4: w1 now heading down again
    run_frame(lat, b1, x0, y0);
    chk("f4_y1_down", gy(1), 4);
    chk("f4_x2", gx(2), 618);
    chk("f4_x3_hold", gx(3), 10);

    // Frame 5: second VBlank edge during UPDATE must be dropped
    tick();
    VBlank = 1'b1;
    tick();
    tick();
    VBlank = 1'b0;
    tick();
    VBlank = 1'b1;
    lat = -1;
    for (int c = 4; c <= 20; c++) begin
      tick();
      if (update_done) begin
        lat = c;
        break;
      end
    end
    chk("f5_lat", lat, 5);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (busy || update_done) seen = 1'b1;
    end
    chk("f5_no_requeue", seen, 0);
    chk("f5_x0", gx(0), 130);
    chk("f5_y1", gy(1), 8);
    chk("f5_x2", gx(2), 612);
    VBlank = 1'b0;

    // Frame 6: reset mid-UPDATE, VBlank held high across release
    tick();
    VBlank = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    #1;
    chk("mid_rst_posX", posX, 64'd0);
    chk("mid_rst_posY", posY, 64'd0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", update_done, 0);
    tick();
    Reset = 1'b1;
    #1;
    chk("rel_init_busy", busy, 1);
    tick();
    chk("rel_x0", gx(0), 100);
    chk("rel_y1", gy(1), 3);
    chk("rel_x2", gx(2), 632);
    tick();
    tick();
    chk("rel_no_trigger", busy, 0);
    chk("rel_no_done", update_done, 0);
    VBlank = 1'b0;

    // Frame 7: directions were restored to positive by reset
    run_frame(lat, b1, x0, y0);
    chk("f7_lat", lat, 5);
    chk("f7_x2", gx(2), 636);
    chk("f7_y1", gy(1), 7);
    chk("f7_x0", gx(0), 106);
    chk("f7_y0", gy(0), 50);

`ifdef WIDGET_PAUSE_EN
    pause = 1'b1;
    tick();
    VBlank = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (busy || update_done) seen = 1'b1;
    end
    chk("pause_quiet", seen, 0);
    chk("pause_x0", gx(0), 106);
    chk("pause_x2", gx(2), 636);
    chk("pause_y1", gy(1), 7);
    VBlank = 1'b0;
    pause  = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
